// File: rtl/retire_trace_tx.sv
// retire_trace_tx: buffers retire events in a small FIFO and serializes each
// one as a 3-5 word trace record on a registered 16-bit valid/ready stream.
module retire_trace_tx #(
    parameter int DEPTH  = 8,
    parameter int DROP_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              retire_valid,
    input  logic [15:0]       pc,
    input  logic              reg_write,
    input  logic [3:0]        write_reg,
    input  logic [15:0]       write_data,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [15:0]       mem_addr,
    input  logic [15:0]       mem_data,
    input  logic              hlt,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [15:0]       out_data,
    output logic              out_last,
    output logic              overflow,
    output logic [DROP_W-1:0] drop_cnt,
    output logic              done,
    output logic              fifo_empty
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [2:0] {IDLE, HDR, INUM, PC, VAL, ADDR} stateT;

    typedef struct packed {
        logic [1:0]  kind;
        logic        halt;
        logic [3:0]  wreg;
        logic [15:0] inum;
        logic [15:0] pc;
        logic [15:0] value;
        logic [15:0] addr;
    } entryT;

    function automatic logic [15:0] hdrWord(input entryT e);
        return {e.kind, e.halt, e.wreg, 9'd0};
    endfunction

    entryT       mem [DEPTH];
    entryT       head, newEntry;
    logic [15:0] nextHdr;
    logic [1:0]  newKind;
    logic [AW:0] wrPtr, rdPtr, count;
    logic [15:0] inumCnt;
    logic        captureEn, haltDropped;
    logic        capture, full, push, drop, pop, hs, more;
    stateT       state, stateNext;
    logic [15:0] dataNext;
    logic        lastNext, validNext;

    assign newKind  = hlt ? 2'd0 : mem_write ? 2'd3 : (mem_read && reg_write) ? 2'd2 : reg_write ? 2'd1 : 2'd0;
    assign newEntry = {newKind, hlt, (newKind == 2'd1 || newKind == 2'd2) ? write_reg : 4'd0,
                       inumCnt, pc, newKind == 2'd3 ? mem_data : write_data, mem_addr};

    assign count      = wrPtr - rdPtr;
    assign full       = count == (AW+1)'(DEPTH);
    assign fifo_empty = count == '0;
    assign more       = count > (AW+1)'(1);
    assign capture    = retire_valid && captureEn;
    assign push       = capture && !full;
    // a full FIFO drops the event even if the head pops on the same edge
    assign drop       = capture && full;
    assign hs         = out_valid && out_ready;
    assign head       = mem[rdPtr[AW-1:0]];
    assign nextHdr    = hdrWord(mem[rdPtr[AW-1:0] + AW'(1)]);

    always_ff @(posedge clk)
        if (push) mem[wrPtr[AW-1:0]] <= newEntry;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrPtr       <= '0;
            rdPtr       <= '0;
            inumCnt     <= '0;
            captureEn   <= 1'b1;
            haltDropped <= 1'b0;
            overflow    <= 1'b0;
            drop_cnt    <= '0;
            done        <= 1'b0;
        end else begin
            if (push) wrPtr <= wrPtr + (AW+1)'(1);
            if (pop) rdPtr <= rdPtr + (AW+1)'(1);
            if (capture) inumCnt <= inumCnt + 16'd1;
            if (capture && hlt) captureEn <= 1'b0;
            if (drop) begin
                overflow    <= 1'b1;
                haltDropped <= haltDropped | hlt;
                if (drop_cnt != '1) drop_cnt <= drop_cnt + DROP_W'(1);
            end
            if ((pop && head.halt) || (haltDropped && fifo_empty)) done <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
        end else begin
            state     <= stateNext;
            out_valid <= validNext;
            out_data  <= dataNext;
            out_last  <= lastNext;
        end
    end

    // state names the word currently presented on out_data
    always_comb begin
        stateNext = state;
        validNext = out_valid;
        dataNext  = out_data;
        lastNext  = out_last;
        pop       = 1'b0;
        if (state == IDLE) begin
            if (!fifo_empty) begin
                stateNext = HDR;
                validNext = 1'b1;
                dataNext  = hdrWord(head);
                lastNext  = 1'b0;
            end
        end else if (hs && out_last) begin
            pop       = 1'b1;
            stateNext = more ? HDR : IDLE;
            validNext = more;
            dataNext  = more ? nextHdr : 16'd0;
            lastNext  = 1'b0;
        end else if (hs) begin
            case (state)
                HDR: begin
                    stateNext = INUM;
                    dataNext  = head.inum;
                    lastNext  = 1'b0;
                end
                INUM: begin
                    stateNext = PC;
                    dataNext  = head.pc;
                    lastNext  = head.kind == 2'd0;
                end
                PC: begin
                    stateNext = VAL;
                    dataNext  = head.value;
                    lastNext  = head.kind == 2'd1;
                end
                default: begin
                    stateNext = ADDR;
                    dataNext  = head.addr;
                    lastNext  = 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_retire_trace_tx.sv
// tb_retire_trace_tx: scoreboard bench; a record-level model predicts words,
// stream timing, drops and done, and a negedge monitor compares.
module tb_retire_trace_tx;
    localparam int DEPTH  = 8;
    localparam int DROP_W = 8;
    localparam int SAT    = (1 << DROP_W) - 1;

    logic              clk = 0, rst = 0;
    logic              retire_valid = 0, reg_write = 0, mem_read = 0, mem_write = 0, hlt = 0, out_ready = 0;
    logic [15:0]       pc = 0, write_data = 0, mem_addr = 0, mem_data = 0;
    logic [3:0]        write_reg = 0;
    logic              out_valid, out_last, overflow, done, fifo_empty;
    logic [15:0]       out_data;
    logic [DROP_W-1:0] drop_cnt;

    retire_trace_tx #(.DEPTH(DEPTH), .DROP_W(DROP_W)) dut (
        .clk(clk), .rst(rst), .retire_valid(retire_valid), .pc(pc), .reg_write(reg_write),
        .write_reg(write_reg), .write_data(write_data), .mem_read(mem_read), .mem_write(mem_write),
        .mem_addr(mem_addr), .mem_data(mem_data), .hlt(hlt), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_last(out_last), .overflow(overflow),
        .drop_cnt(drop_cnt), .done(done), .fifo_empty(fifo_empty)
    );

    always #5 clk = ~clk;

    typedef struct { int len; bit halt; } rec_t;
    rec_t        mq[$];
    logic [16:0] expQ[$];
    int          errors = 0, checks = 0;
    bit          mPres, mOvf, mDone, mCapEn, mHaltDrop;
    int          mPos, mDrops;
    logic [15:0] mInum;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void modelReset();
        mq.delete();
        expQ.delete();
        mPres = 0; mOvf = 0; mDone = 0; mCapEn = 1; mHaltDrop = 0;
        mPos = 0; mDrops = 0; mInum = 0;
    endfunction

    function automatic void modelStep();
        int occ = mq.size();
        bit cap = retire_valid && mCapEn;
        bit pushNew = 0;
        rec_t r;
        int kind, wr;
        logic [15:0] hdr;
        if (mHaltDrop && occ == 0) mDone = 1;
        if (cap) begin
            kind = hlt ? 0 : mem_write ? 3 : (mem_read && reg_write) ? 2 : reg_write ? 1 : 0;
            if (occ == DEPTH) begin
                mOvf = 1;
                if (mDrops < SAT) mDrops++;
                if (hlt) mHaltDrop = 1;
            end else begin
                wr = (kind == 1 || kind == 2) ? int'(write_reg) : 0;
                hdr = 16'(kind * 16384 + (hlt ? 8192 : 0) + wr * 512);
                r.len = kind == 0 ? 3 : kind == 1 ? 4 : 5;
                r.halt = hlt;
                pushNew = 1;
                expQ.push_back({1'b0, hdr});
                expQ.push_back({1'b0, mInum});
                expQ.push_back({r.len == 3, pc});
                if (kind > 0) expQ.push_back({r.len == 4, kind == 3 ? mem_data : write_data});
                if (kind > 1) expQ.push_back({1'b1, mem_addr});
            end
            if (hlt) mCapEn = 0;
            mInum++;
        end
        if (mPres && out_ready) begin
            if (mPos == mq[0].len - 1) begin
                if (mq[0].halt) mDone = 1;
                void'(mq.pop_front());
                mPres = mq.size() > 0;
                mPos = 0;
            end else mPos++;
        end else if (!mPres && occ > 0) begin
            mPres = 1;
            mPos = 0;
        end
        if (pushNew) mq.push_back(r);
    endfunction

    task automatic cyc(input bit rv, input bit h, input bit mw, input bit mr, input bit rw, input bit rdy);
        retire_valid = rv; hlt = h; mem_write = mw; mem_read = mr; reg_write = rw; out_ready = rdy;
        @(posedge clk);
        modelStep();
        #1;
    endtask

    task automatic randData();
        pc = 16'($urandom); write_reg = 4'($urandom); write_data = 16'($urandom);
        mem_addr = 16'($urandom); mem_data = 16'($urandom);
    endtask

    task automatic doReset();
        retire_valid = 0; hlt = 0; mem_write = 0; mem_read = 0; reg_write = 0; out_ready = 0;
        rst = 1;
        #1;
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_last", out_last, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_drop_cnt", drop_cnt, 0);
        chk("rst_done", done, 0);
        chk("rst_empty", fifo_empty, 1);
        modelReset();
        repeat (2) @(posedge clk);
        #1 rst = 0;
    endtask

    bit          stall = 0;
    logic [15:0] holdD;
    logic        holdL;
    logic [16:0] e;

    always @(negedge clk) begin
        if (rst) stall = 0;
        else begin
            chk("valid", out_valid, mPres);
            chk("fifo_empty", fifo_empty, mq.size() == 0);
            chk("overflow", overflow, mOvf);
            chk("drop_cnt", drop_cnt, mDrops);
            chk("done", done, mDone);
            if (stall) begin
                chk("hold_data", out_data, holdD);
                chk("hold_last", out_last, holdL);
            end
            if (out_valid && out_ready) begin
                if (expQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL extra_word: got %0h expected no word at %0t", out_data, $time);
                end else begin
                    e = expQ.pop_front();
                    chk("word", out_data, e[15:0]);
                    chk("last", out_last, e[16]);
                end
            end
            stall = out_valid && !out_ready;
            holdD = out_data;
            holdL = out_last;
        end
    end

    initial begin
        #2 doReset();
        pc = 16'h0004; write_reg = 4'd3; write_data = 16'hBEEF;
        cyc(1, 0, 0, 0, 1, 1);
        repeat (8) cyc(0, 0, 0, 0, 0, 1);

        doReset();
        pc = 16'h0020; write_reg = 4'd5; write_data = 16'h1234; mem_addr = 16'h0010;
        cyc(1, 0, 0, 1, 1, 1);
        pc = 16'h0022; mem_data = 16'h5678;
        cyc(1, 0, 1, 0, 0, 0);
        for (int i = 0; i < 24; i++) cyc(0, 0, 0, 0, 0, 1'(i));

        doReset();
        repeat (11) cyc(1, 0, 0, 0, 0, 0);
        chk("nop_drop_cnt", drop_cnt, 3);
        chk("nop_overflow", overflow, 1);
        repeat (3) cyc(1, 0, 0, 0, 0, 1);
        chk("fullpop_drop_cnt", drop_cnt, 6);
        repeat (40) cyc(0, 0, 0, 0, 0, 1);
        chk("drained_empty", fifo_empty, 1);

        doReset();
        repeat (2) begin randData(); cyc(1, 0, 0, 0, 1, 1); end
        randData(); cyc(1, 1, 0, 0, 0, 1);
        repeat (3) begin randData(); cyc(1, 0, 0, 0, 1, 1); end
        repeat (20) cyc(0, 0, 0, 0, 0, 1);
        chk("halt_done", done, 1);
        chk("halt_drop_cnt", drop_cnt, 0);

        doReset();
        repeat (300) cyc(1, 0, 0, 0, 0, 0);
        chk("drop_saturate", drop_cnt, SAT);

        doReset();
        randData(); cyc(1, 0, 1, 0, 0, 0);
        repeat (3) cyc(0, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 0);
        chk("pre_reset_valid", out_valid, 1);
        doReset();
        randData(); cyc(1, 0, 0, 0, 1, 1);
        repeat (8) cyc(0, 0, 0, 0, 0, 1);

        for (int s = 0; s < 6; s++) begin
            doReset();
            for (int i = 0; i < 300; i++) begin
                randData();
                cyc($urandom % 3 != 0, $urandom % 80 == 0, $urandom % 4 == 0, 1'($urandom), 1'($urandom),
                    $urandom % (s % 3 + 2) != 0);
            end
            repeat (60) cyc(0, 0, 0, 0, 0, 1);
        end
        chk("scoreboard_empty", expQ.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
